// File: rtl/shift_sequencer.sv
// Sequences multi-step logical shifts through an external 1-bit-per-cycle shift unit.
// Optional WAIT timeout enabled by defining SHIFT_SEQ_TIMEOUT_EN.
module shift_sequencer #(
    parameter int Width   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [Width-1:0] cmd_data,
    input  logic [4:0]       cmd_amt,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [Width-1:0] res_data,
    output logic             res_err,
    output logic             su_enable,
    output logic [1:0]       su_fun,
    output logic [Width-1:0] su_a,
    output logic [Width-1:0] su_b,
    input  logic [Width-1:0] su_out,
    input  logic             su_flag
);

    localparam int CW = $clog2(Width + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_next;
    logic [Width-1:0] work, work_next;
    logic             dir, dir_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [CW-1:0]    amt_clamped;
    logic             load_su;

`ifdef SHIFT_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wcnt;
    logic          err, err_next;
`endif

    assign amt_clamped = (int'(cmd_amt) >= Width) ? CW'(Width) : CW'(cmd_amt);

    // Ready is gated by reset so it reads 0 while RST is held low.
    assign cmd_ready = (state == IDLE) && RST;
    assign res_valid = (state == RESP);
    assign res_data  = work;
    assign su_enable = (state == ISSUE);
    assign su_b      = '0;

`ifdef SHIFT_SEQ_TIMEOUT_EN
    assign res_err = err;
`else
    assign res_err = 1'b0;
`endif

    always_comb begin
        state_next = state;
        work_next  = work;
        dir_next   = dir;
        cnt_next   = cnt;
        load_su    = 1'b0;
`ifdef SHIFT_SEQ_TIMEOUT_EN
        err_next   = err;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    work_next = cmd_data;
                    dir_next  = cmd_dir;
                    cnt_next  = amt_clamped;
`ifdef SHIFT_SEQ_TIMEOUT_EN
                    err_next  = 1'b0;
`endif
                    if (amt_clamped == '0) begin
                        state_next = RESP;
                    end else begin
                        state_next = ISSUE;
                        load_su    = 1'b1;
                    end
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (su_flag) begin
                    work_next = su_out;
                    cnt_next  = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state_next = RESP;
                    end else begin
                        state_next = ISSUE;
                        load_su    = 1'b1;
                    end
                end
`ifdef SHIFT_SEQ_TIMEOUT_EN
                else if (wcnt == TW'(TIMEOUT - 1)) begin
                    state_next = RESP;
                    err_next   = 1'b1;
                end
`endif
            end
            RESP: begin
                if (res_ready) begin
                    state_next = IDLE;
`ifdef SHIFT_SEQ_TIMEOUT_EN
                    err_next   = 1'b0;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // su_a/su_fun are loaded only on the way into ISSUE so they hold between pulses.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state  <= IDLE;
            work   <= '0;
            dir    <= 1'b0;
            cnt    <= '0;
            su_a   <= '0;
            su_fun <= '0;
        end else begin
            state <= state_next;
            work  <= work_next;
            dir   <= dir_next;
            cnt   <= cnt_next;
            if (load_su) begin
                su_a   <= work_next;
                su_fun <= {1'b0, dir_next};
            end
        end
    end

`ifdef SHIFT_SEQ_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wcnt <= '0;
            err  <= 1'b0;
        end else begin
            err <= err_next;
            if (state_next == WAIT && state != WAIT)
                wcnt <= '0;
            else if (state == WAIT && !su_flag)
                wcnt <= wcnt + TW'(1);
        end
    end
`endif

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter Width, default 16, operand/result width; SHALL equal the attached shift unit width.
REQ-002 Parameter TIMEOUT, default 8, max wait cycles for su_flag (used only with SHIFT_SEQ_TIMEOUT_EN).
REQ-003 Reset RST, asynchronous, active-low; clock CLK.
REQ-004 CLK  in  1  rising-edge clock.
REQ-005 RST  in  1  async active-low reset.
REQ-006 cmd_valid  in  1  command present.
REQ-007 cmd_ready  out  1  sequencer accepts command.
REQ-008 cmd_dir  in  1  0 = shift right, 1 = shift left (logical).
REQ-009 cmd_data  in  Width  operand.
REQ-010 cmd_amt  in  5  shift distance, 0..31.
REQ-011 res_valid  out  1  result present.
REQ-012 res_ready  in  1  consumer accepts result.
REQ-013 res_data  out  Width  shifted result.
REQ-014 res_err  out  1  result aborted by timeout; qualified by res_valid.
REQ-015 su_enable  out  1  drives shift unit Shift_Enable.
REQ-016 su_fun  out  2  drives shift unit ALU_FUN; SHALL be 2'b00 (A right) or 2'b01 (A left) only.
REQ-017 su_a  out  Width  drives shift unit A.
REQ-018 su_b  out  Width  drives shift unit B; SHALL be constant zero.
REQ-019 su_out  in  Width  shift unit Shift_OUT (1-cycle registered 1-bit shift).
REQ-020 su_flag  in  1  shift unit Shift_Flag.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; all outputs registered or decoded from state/registers only.
REQ-022 IDLE: cmd_ready=1; on cmd_valid&cmd_ready edge, latch work=cmd_data, dir=cmd_dir, cnt=min(cmd_amt,Width).
REQ-023 Accept with cnt=0 SHALL go directly to RESP with res_data=cmd_data, no su_enable pulse.
REQ-024 Accept with cnt>0 SHALL go to ISSUE.
REQ-025 ISSUE: su_enable=1, su_a=work, su_fun={1'b0,dir} for exactly one cycle; next state WAIT.
REQ-026 WAIT: su_enable=0; if su_flag=1, work<=su_out, cnt<=cnt-1; then ISSUE if cnt-1>0 else RESP.
REQ-027 WAIT with su_flag=0 SHALL remain in WAIT (timeout behaviour per Configuration).
REQ-028 Latency: with su_flag well-behaved, res_valid SHALL assert 2*cnt+1 clock edges after accept (1 edge for cnt=0).
REQ-029 cmd_amt>=Width SHALL clamp to Width steps; result 0.
REQ-030 RESP: res_valid=1, res_data=work, cmd_ready=0; hold all until res_valid&res_ready edge, then IDLE.
REQ-031 Command-accept and result-handshake edges SHALL never coincide (no back-to-back bypass); minimum 1 IDLE cycle between commands.
REQ-032 su_a, su_fun SHALL hold last driven value while su_enable=0.

Reset
REQ-033 RST low SHALL force state IDLE, cmd_ready=0 during reset then 1 in IDLE, res_valid=0, res_data=0, res_err=0, su_enable=0, su_fun=0, su_a=0, work=0, cnt=0.
REQ-034 Reset mid-operation SHALL abandon the command without emitting a result.

Configuration
REQ-035 Macro SHIFT_SEQ_TIMEOUT_EN: when defined, a wait counter SHALL count WAIT cycles with su_flag=0; on reaching TIMEOUT, go to RESP with res_err=1, res_data=work as captured so far.
REQ-036 Counter SHALL clear on entering WAIT; res_err SHALL clear on leaving RESP.
REQ-037 Without SHIFT_SEQ_TIMEOUT_EN: no counter, WAIT waits indefinitely, res_err tied 0.

Verification
REQ-038 dir=1, data=0x0001, amt=3, res_ready=1 -> three su_enable pulses, res_data=0x0008, res_err=0, res_valid 7 edges after accept.
REQ-039 dir=0, data=0x8000, amt=0 -> no su_enable pulse, res_data=0x8000 one edge after accept.
REQ-040 dir=1, data=0xFFFF, amt=20 -> 16 steps, res_data=0x0000.
REQ-041 amt=2, res_ready low 5 cycles -> res_valid, res_data stable throughout, cmd_ready=0; completes on res_ready=1, then IDLE.
REQ-042 RST low during WAIT of amt=4 -> all outputs reset values immediately; no res_valid after release; next command dir=0, 0x0010, amt=1 -> 0x0008.
REQ-043 SHIFT_SEQ_TIMEOUT_EN, TIMEOUT=8, su_flag held 0 -> res_valid with res_err=1 after 8 WAIT cycles; without macro, stays in WAIT.
